imm_decode_pipe: RTL and testbench
==================================

IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, output datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width; 5 when XLEN=32, 6 when XLEN=64.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-006 SHALL have port in_valid, input, 1, upstream instruction valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept this cycle.
REQ-008 SHALL have port in_instr, input, 32, raw RV instruction word.
REQ-009 SHALL have port in_pc, input, XLEN, instruction address.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts.
REQ-012 SHALL have port out_imm, output, XLEN, decoded immediate.
REQ-013 SHALL have port out_fmt, output, 3, format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 SHAMT.
REQ-014 SHALL have port out_target, output, XLEN, in_pc + out_imm modulo 2^XLEN.
REQ-015 SHALL have port out_illegal, output, 1, unsupported opcode.

Function
REQ-016 I-format, sign-extended from instr[31:20]: opcodes 0010011 (except shifts), 0000011, 1100111, and 1110011 with funct3[2]=0.
REQ-017 SHAMT, zero-extended from instr[SHAMT_W+19:20]: opcode 0010011 with funct3 001 or 101; and 0011011 with funct3 001/101, using instr[24:20].
REQ-018 Opcode 0011011 with other funct3 is I-format when XLEN=64 and illegal when XLEN=32.
REQ-019 S-format: {instr[31:25],instr[11:7]}, sign-extended.
REQ-020 B-format: {instr[31],instr[7],instr[30:25],instr[11:8],0}, sign-extended.
REQ-021 U-format, opcodes 0110111 and 0010111: {instr[31:12],12'b0}, sign-extended from bit 31 to XLEN.
REQ-022 J-format: {instr[31],instr[19:12],instr[20],instr[30:21],0}, sign-extended.
REQ-023 Z-format: opcode 1110011 with funct3[2]=1; instr[19:15] zero-extended.
REQ-024 NONE, illegal=0, imm=0: opcodes 0110011, 0111011, 0001111.
REQ-025 All other opcodes: fmt NONE, imm 0, illegal=1.
REQ-026 Storage: one output register plus one skid register, each with its own valid bit.
REQ-027 in_ready SHALL equal !skid_valid, a registered signal with no combinational path from out_ready.
REQ-028 Accept occurs when in_valid && in_ready.
REQ-029 Latency: an entry accepted at edge N is presented with out_valid=1 after edge N, when the output register was free or drained at N.
REQ-030 Output register is loaded when it is empty or out_ready=1: from skid if skid_valid, else from the accepted input.
REQ-031 An accept while the output is held (out_valid && !out_ready) SHALL go to skid.
REQ-032 Order SHALL be preserved, with no loss or duplication.
REQ-033 Outputs SHALL stay stable while out_valid && !out_ready.
REQ-034 flush=1 SHALL clear both valid bits at the next edge and drop any same-cycle accept; flush has priority over all other events.
REQ-035 Simultaneous out drain and accept with empty skid SHALL pass the new entry straight to the output register.

Reset
REQ-036 rst_n low SHALL immediately force out_valid=0, skid_valid=0, in_ready=1, out_imm=0, out_target=0, out_fmt=0, out_illegal=0.
REQ-037 Reset asserted mid-stall SHALL discard held entries; the first accept after release behaves as from empty.

Verification
REQ-038 XLEN=32: 0xFFF00093, pc 0x0 -> next cycle imm 0xFFFFFFFF, fmt 1, target 0xFFFFFFFF.
REQ-039 0xFE000EE3 (beq -4), pc 0x100 -> imm 0xFFFFFFFC, fmt 3, target 0x000000FC.
REQ-040 XLEN=64: 0x800000B7 -> imm 0xFFFFFFFF80000000, fmt 4; 0x0000007F -> illegal=1, imm 0.
REQ-041 out_ready low for 3 cycles, 3 back-to-back inputs -> two accepted, in_ready=0 on third; after release, outputs arrive in order.
REQ-042 flush while both entries are held -> out_valid=0 and in_ready=1 next cycle; rst_n pulse mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/imm_decode_pipe.sv
// RISC-V immediate decoder feeding a two-entry (output + skid) valid/ready pipeline.
// Each held entry carries the decoded immediate, format code, branch/jump target and illegal flag.
module imm_decode_pipe #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_Z     = 3'd6,
    FMT_SHAMT = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    fmt_e            fmt;
    logic            ill;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_shift;
  logic [31:0] raw;
  fmt_e        dec_fmt;
  logic        dec_ill;
  entry_t      dec;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // All formats fit in a 32-bit signed value; widening to XLEN is one sign extension.
  always_comb begin
    raw     = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opcode)
      7'b0010011: begin
        if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          raw     = 32'(in_instr[SHAMT_W+19:20]);
        end else begin
          dec_fmt = FMT_I;
          raw     = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b0011011: begin
        if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          raw     = 32'(in_instr[24:20]);
        end else if (XLEN == 64) begin
          dec_fmt = FMT_I;
          raw     = {{20{in_instr[31]}}, in_instr[31:20]};
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        raw     = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b1110011: begin
        if (funct3[2]) begin
          dec_fmt = FMT_Z;
          raw     = 32'(in_instr[19:15]);
        end else begin
          dec_fmt = FMT_I;
          raw     = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        raw     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        raw     = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        raw     = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        raw     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      7'b0110011, 7'b0111011, 7'b0001111: begin
        dec_fmt = FMT_NONE;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    dec.imm = XLEN'($signed(raw));
    dec.tgt = in_pc + XLEN'($signed(raw));
    dec.fmt = dec_fmt;
    dec.ill = dec_ill;
  end

  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic   accept;

  // in_ready depends only on the skid flop, so out_ready never reaches it combinationally.
  assign accept = in_valid && !skid_valid_q && !flush;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_d = dec;
        end
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready    = !skid_valid_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_target  = out_q.tgt;
  assign out_illegal = out_q.ill;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed bench for imm_decode_pipe at XLEN=32 and XLEN=64, with scoreboard queues
// filled by the driver and drained by per-instance output monitors.
module tb_imm_decode_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic clk, rst_n, flush;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, out_ill32;
  logic [31:0] in_instr32, in_pc32, out_imm32, out_tgt32;
  logic [2:0]  out_fmt32;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, out_ill64;
  logic [31:0] in_instr64;
  logic [63:0] in_pc64, out_imm64, out_tgt64;
  logic [2:0]  out_fmt64;

  exp_t q32[$];
  exp_t q64[$];
  int   n_cmp = 0;
  int   n_err = 0;

  imm_decode_pipe #(.XLEN(32), .SHAMT_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_instr(in_instr32), .in_pc(in_pc32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_target(out_tgt32), .out_illegal(out_ill32)
  );

  imm_decode_pipe #(.XLEN(64), .SHAMT_W(6)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_target(out_tgt64), .out_illegal(out_ill64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transfers happen at the next posedge when valid && ready are seen here.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid32 && out_ready32) begin
      exp_t e;
      if (q32.size() == 0) begin
        chk("x32_unexpected_output", 64'(out_imm32), 64'hDEAD);
      end else begin
        e = q32.pop_front();
        chk("x32_vec", {17'(out_imm32), 17'(out_tgt32), 3'(out_fmt32), out_ill32, 26'd0},
            {17'(e.imm), 17'(e.tgt), e.fmt, e.ill, 26'd0});
        if (out_imm32 !== e.imm[31:0] || out_tgt32 !== e.tgt[31:0])
          chk("x32_full", {out_imm32, out_tgt32}, {e.imm[31:0], e.tgt[31:0]});
      end
    end
    if (rst_n && !flush && out_valid64 && out_ready64) begin
      exp_t e;
      if (q64.size() == 0) begin
        chk("x64_unexpected_output", out_imm64, 64'hDEAD);
      end else begin
        e = q64.pop_front();
        chk("x64_imm", out_imm64, e.imm);
        if (out_tgt64 !== e.tgt) chk("x64_tgt", out_tgt64, e.tgt);
        if ({out_fmt64, out_ill64} !== {e.fmt, e.ill})
          chk("x64_fmt_ill", 64'({out_fmt64, out_ill64}), 64'({e.fmt, e.ill}));
      end
    end
  end

  task automatic send32(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] tgt, input logic [2:0] fmt, input logic ill);
    int unsigned t = 0;
    logic ok = 1'b0;
    in_instr32 = ins;
    in_pc32    = pc;
    in_valid32 = 1'b1;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = in_ready32;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid32 = 1'b0;
    if (ok) q32.push_back('{imm: {32'd0, imm}, tgt: {32'd0, tgt}, fmt: fmt, ill: ill});
    else chk("x32_accept_timeout", 64'(t), 64'd0);
  endtask

  task automatic send64(input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] imm,
                        input logic [63:0] tgt, input logic [2:0] fmt, input logic ill);
    int unsigned t = 0;
    logic ok = 1'b0;
    in_instr64 = ins;
    in_pc64    = pc;
    in_valid64 = 1'b1;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = in_ready64;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid64 = 1'b0;
    if (ok) q64.push_back('{imm: imm, tgt: tgt, fmt: fmt, ill: ill});
    else chk("x64_accept_timeout", 64'(t), 64'd0);
  endtask

  task automatic drain(input string name);
    int unsigned t = 0;
    while ((q32.size() != 0 || q64.size() != 0) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(name, 64'(q32.size() + q64.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    in_valid32 = 1'b0; in_instr32 = '0; in_pc32 = '0; out_ready32 = 1'b1;
    in_valid64 = 1'b0; in_instr64 = '0; in_pc64 = '0; out_ready64 = 1'b1;
    #12;
    chk("reset_out_valid", 64'(out_valid32), 64'd0);
    chk("reset_in_ready", 64'(in_ready32), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decode coverage at XLEN=32.
    send32(32'hFFF00093, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0);
    send32(32'hFE000EE3, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0000_00FC, 3'd3, 1'b0);
    send32(32'h0020A423, 32'h0000_1000, 32'h0000_0008, 32'h0000_1008, 3'd2, 1'b0);
    send32(32'h123452B7, 32'h0000_0010, 32'h1234_5000, 32'h1234_5010, 3'd4, 1'b0);
    send32(32'h0010006F, 32'h0000_0200, 32'h0000_0800, 32'h0000_0A00, 3'd5, 1'b0);
    send32(32'h8000006F, 32'h0000_0000, 32'hFFF0_0000, 32'hFFF0_0000, 3'd5, 1'b0);
    send32(32'h41F0D093, 32'h0000_0004, 32'h0000_001F, 32'h0000_0023, 3'd7, 1'b0);
    send32(32'h03F09093, 32'h0000_0000, 32'h0000_001F, 32'h0000_001F, 3'd7, 1'b0);
    send32(32'h300FD073, 32'h0000_0000, 32'h0000_001F, 32'h0000_001F, 3'd6, 1'b0);
    send32(32'h002081B3, 32'h0000_0040, 32'h0000_0000, 32'h0000_0040, 3'd0, 1'b0);
    send32(32'h0000007F, 32'h0000_0050, 32'h0000_0000, 32'h0000_0050, 3'd0, 1'b1);
    send32(32'h0010809B, 32'h0000_0060, 32'h0000_0000, 32'h0000_0060, 3'd0, 1'b1);
    send32(32'h00000073, 32'h0000_0070, 32'h0000_0000, 32'h0000_0070, 3'd1, 1'b0);
    send32(32'h80002083, 32'h0000_0800, 32'hFFFF_F800, 32'h0000_0000, 3'd1, 1'b0);
    drain("drain_decode");

    // Stall: two accepted, third blocked, then in-order release.
    out_ready32 = 1'b0;
    send32(32'h00100093, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 3'd1, 1'b0);
    send32(32'h00200093, 32'h0000_0000, 32'h0000_0002, 32'h0000_0002, 3'd1, 1'b0);
    in_instr32 = 32'h00300093;
    in_pc32    = 32'h0;
    in_valid32 = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready32), 64'd0);
      chk("stall_hold_imm", 64'(out_imm32), 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready32 = 1'b1;
    send32(32'h00300093, 32'h0000_0000, 32'h0000_0003, 32'h0000_0003, 3'd1, 1'b0);
    drain("drain_stall");

    // Flush with both entries held; same-cycle input is dropped.
    out_ready32 = 1'b0;
    send32(32'h00400093, 32'h0, 32'h4, 32'h4, 3'd1, 1'b0);
    send32(32'h00500093, 32'h0, 32'h5, 32'h5, 3'd1, 1'b0);
    chk("pre_flush_in_ready", 64'(in_ready32), 64'd0);
    in_instr32 = 32'h00600093;
    in_valid32 = 1'b1;
    flush      = 1'b1;
    @(posedge clk);
    #1;
    flush      = 1'b0;
    in_valid32 = 1'b0;
    q32.delete();
    chk("flush_out_valid", 64'(out_valid32), 64'd0);
    chk("flush_in_ready", 64'(in_ready32), 64'd1);
    out_ready32 = 1'b1;
    send32(32'h00700093, 32'h0000_0010, 32'h0000_0007, 32'h0000_0017, 3'd1, 1'b0);
    drain("drain_flush");

    // Asynchronous reset mid-stall.
    out_ready32 = 1'b0;
    send32(32'h0000007F, 32'h0000_0050, 32'h0, 32'h0000_0050, 3'd0, 1'b1);
    send32(32'hFFF00093, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_in_ready", 64'(in_ready32), 64'd1);
    chk("rst_out_imm", 64'(out_imm32), 64'd0);
    chk("rst_out_target", 64'(out_tgt32), 64'd0);
    chk("rst_out_fmt_ill", 64'({out_fmt32, out_ill32}), 64'd0);
    q32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready32 = 1'b1;
    @(posedge clk);
    #1;
    send32(32'h0020A423, 32'h0000_1000, 32'h0000_0008, 32'h0000_1008, 3'd2, 1'b0);
    drain("drain_reset");

    // XLEN=64 instance.
    send64(32'h800000B7, 64'h0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    send64(32'h0000007F, 64'h20, 64'h0, 64'h20, 3'd0, 1'b1);
    send64(32'h0010809B, 64'h0, 64'h1, 64'h1, 3'd1, 1'b0);
    send64(32'h03F09093, 64'h0, 64'h3F, 64'h3F, 3'd7, 1'b0);
    send64(32'h03F0909B, 64'h0, 64'h1F, 64'h1F, 3'd7, 1'b0);
    send64(32'hFE000EE3, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFC, 3'd3, 1'b0);
    drain("drain_x64");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
